rs_dispatch_arbiter: RTL and testbench
======================================

// Module: rs_dispatch_arbiter
// PURPOSE
//  Selects one ready reservation-station entry per cycle and hands its operation to the functional unit.
//  It is the read-out counterpart of the issue path: issue loads entries by res_station_id, this block encodes a ready entry back to an id.
//  It frees the chosen entry and presents op/Vj/Vk/dest tag on a registered valid/ready interface.
//  It sits between the RS bank of one functional unit and that FU's input stage.
// PARAMETERS
//  NUM_RS   3   number of RS entries (ids 0..NUM_RS-1); must be <= 8
//  ID_W     3   width of res_station_id
//  TAG_W    3   ROB/destination tag width
//  CNT_W    16  dispatch performance counter width
// PORTS
//  clk            in   1            single clock, rising edge
//  reset_n        in   1            asynchronous, active-low reset
//  flush          in   1            synchronous pipeline flush
//  rs_ready       in   NUM_RS       entry busy and both Qj/Qk resolved
//  rs_op          in   lc3b_aluop   per-entry operation (unpacked [NUM_RS])
//  rs_Vj, rs_Vk   in   lc3b_word    per-entry operands (unpacked [NUM_RS])
//  rs_dest        in   TAG_W        per-entry destination tag (unpacked [NUM_RS])
//  rs_clear       out  NUM_RS       one-hot pulse: free that entry at this edge
//  fu_valid       out  1            payload valid
//  fu_ready       in   1            FU accepts payload
//  fu_op          out  lc3b_aluop   registered op
//  fu_a, fu_b     out  lc3b_word    registered Vj, Vk
//  fu_tag         out  TAG_W        registered destination tag
//  fu_rs_id       out  ID_W         id of the source entry
//  dispatch_cnt   out  CNT_W        count of completed FU handshakes, saturating
// BEHAVIOUR
//  Reset (async, reset_n=0): fu_valid=0; fu_op/fu_a/fu_b/fu_tag/fu_rs_id=0; rr_ptr=0; dispatch_cnt=0; rs_clear=0 (combinational, forced 0 while reset_n=0).
//  FSM of two states.
//  - EMPTY (fu_valid=0): selects an entry if any rs_ready bit is set. On a selection the payload is captured at the next edge and the state goes to FULL.
//  - FULL (fu_valid=1): the payload holds stable until fu_ready=1.
//  - On fu_valid&fu_ready, a new selection may be captured at the same edge, giving back-to-back transfers and 1 dispatch/cycle.
//  Capture enable is cap = (!fu_valid | fu_ready) & |rs_ready & !flush.
//  Selection: round-robin. Search starts at rr_ptr and wraps modulo NUM_RS. The first ready id wins.
//  On capture, rr_ptr <= (win_id+1) mod NUM_RS. The wrap from NUM_RS-1 goes to 0.
//  rs_clear[win_id]=1 combinationally in the same cycle as cap. Exactly one bit or none is set, and none when cap=0.
//  Latency: rs_ready high at cycle t gives fu_valid at t+1 if the block was EMPTY or fu_ready was high at t.
//  Simultaneous transfer and capture: the old payload is consumed and the new one loaded at the same edge, with no bubble.
//  Handshake with no ready entries: fu_valid drops to 0 at that edge.
//  Ready drop: an rs_ready bit deasserting while not selected has no effect. A captured payload is never withdrawn except by flush.
//  flush (priority over everything except reset):
//  - next edge: fu_valid=0, rr_ptr=0, no rs_clear that cycle
//  - a handshake in the flush cycle is not counted
//  dispatch_cnt increments by 1 on each fu_valid&fu_ready edge (not flushed) and saturates at all-ones.
//  Reset mid-transfer: the outputs drop immediately to reset values and no entry is cleared.
//  Assertions: $onehot0(rs_clear); fu_rs_id < NUM_RS whenever fu_valid; payload stable while fu_valid&!fu_ready.
// STRUCTURE
//  lc3b_types package: lc3b_word and lc3b_aluop are used as-is. A new typedef rs_id_t = logic [2:0] is added there and shared with the issue decoder.
//  Sub-module rr_select: combinational round-robin priority encoder (ready vector + ptr -> found, id).
//  The top holds the output register, rr_ptr, the FSM and the counter.
// TESTING
//  1 Reset, then rs_ready=3'b010 with fu_ready=1 -> rs_clear=010 at t0; fu_valid=1 and fu_rs_id=1 at t1; rr_ptr=2.
//  2 rs_ready=3'b111 held and fu_ready=1 for 6 cycles -> fu_rs_id sequence 0,1,2,0,1,2 with fu_valid never low after the first; dispatch_cnt=5 after cycle 6 (5 handshakes).
//  3 Capture id 2 with payload A=16'h1234, then fu_ready=0 for 4 cycles while rs_ready=3'b001 -> fu_a stays 16'h1234, rs_clear=0. When fu_ready=1, id 0 is loaded at the same edge.
//  4 fu_valid=1 and flush=1 with fu_ready=1 -> next cycle fu_valid=0, rs_clear=0 in the flush cycle, dispatch_cnt unchanged, rr_ptr=0.
//  5 Preload dispatch_cnt to 16'hFFFE and perform 3 handshakes -> dispatch_cnt=16'hFFFF, which holds.
//  6 reset_n low mid-cycle while fu_valid=1 -> fu_valid=0 immediately (before the clock edge) and rs_clear=0; normal operation resumes after release.

Source files
------------

// File: rtl/rs_dispatch_arbiter_pkg.sv
// Shared LC-3b datapath types plus the reservation-station id type used by
// the issue decoder and the dispatch arbiter.
package rs_dispatch_arbiter_pkg;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [3:0] {
    AluAdd,
    AluAnd,
    AluNot,
    AluPass,
    AluSll,
    AluSrl,
    AluSra
  } lc3b_aluop;

  typedef logic [2:0] rs_id_t;

  localparam int unsigned WordW  = $bits(lc3b_word);
  localparam int unsigned AluOpW = $bits(lc3b_aluop);

  typedef enum logic [0:0] {
    StEmpty,
    StFull
  } disp_state_e;

  // Successor of an id modulo the number of entries; num_rs is at most 8.
  function automatic rs_id_t rs_id_wrap_inc(rs_id_t id, int unsigned num_rs);
    logic [3:0] nxt;
    nxt = {1'b0, id} + 4'd1;
    if (nxt >= 4'(num_rs)) begin
      nxt = 4'd0;
    end
    return nxt[2:0];
  endfunction

endpackage

// File: rtl/rs_dispatch_arbiter_rr_select.sv
// Round-robin priority encoder: first set ready bit at or after ptr_i,
// wrapping to the lowest set bit below ptr_i.
module rs_dispatch_arbiter_rr_select #(
  parameter int unsigned NUM_RS = 3,
  parameter int unsigned ID_W   = 3
) (
  input  logic [NUM_RS-1:0] ready_i,
  input  logic [ID_W-1:0]   ptr_i,
  output logic              found_o,
  output logic [ID_W-1:0]   id_o
);

  logic            found_hi, found_lo;
  logic [ID_W-1:0] id_hi, id_lo;

  // Descending scan so the last assignment is the lowest qualifying index.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    id_hi    = '0;
    id_lo    = '0;
    for (int i = int'(NUM_RS) - 1; i >= 0; i--) begin
      if (ready_i[i]) begin
        if (ID_W'(i) >= ptr_i) begin
          found_hi = 1'b1;
          id_hi    = ID_W'(i);
        end else begin
          found_lo = 1'b1;
          id_lo    = ID_W'(i);
        end
      end
    end
    found_o = found_hi | found_lo;
    id_o    = found_hi ? id_hi : id_lo;
  end

endmodule

// File: rtl/rs_dispatch_arbiter.sv
// Picks one ready RS entry per cycle, frees it, and presents its payload to the
// functional unit on a registered valid/ready interface.
module rs_dispatch_arbiter
  import rs_dispatch_arbiter_pkg::*;
#(
  parameter int unsigned NUM_RS = 3,
  parameter int unsigned ID_W   = 3,
  parameter int unsigned TAG_W  = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic [NUM_RS-1:0] rs_ready_i,
  input  logic [AluOpW-1:0] rs_op_i   [NUM_RS],
  input  logic [WordW-1:0]  rs_vj_i   [NUM_RS],
  input  logic [WordW-1:0]  rs_vk_i   [NUM_RS],
  input  logic [TAG_W-1:0]  rs_dest_i [NUM_RS],
  output logic [NUM_RS-1:0] rs_clear_o,
  output logic              fu_valid_o,
  input  logic              fu_ready_i,
  output logic [AluOpW-1:0] fu_op_o,
  output logic [WordW-1:0]  fu_a_o,
  output logic [WordW-1:0]  fu_b_o,
  output logic [TAG_W-1:0]  fu_tag_o,
  output logic [ID_W-1:0]   fu_rs_id_o,
  output logic [CNT_W-1:0]  dispatch_cnt_o
);

  disp_state_e       state_q, state_d;
  logic [AluOpW-1:0] op_q, op_d;
  logic [WordW-1:0]  a_q, a_d;
  logic [WordW-1:0]  b_q, b_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              found;
  logic [ID_W-1:0]   win_id;
  logic              valid;
  logic              cap;
  logic              hs;
  logic [AluOpW-1:0] sel_op;
  logic [WordW-1:0]  sel_a, sel_b;
  logic [TAG_W-1:0]  sel_tag;

  rs_dispatch_arbiter_rr_select #(
    .NUM_RS(NUM_RS),
    .ID_W  (ID_W)
  ) u_rr_select (
    .ready_i(rs_ready_i),
    .ptr_i  (rr_ptr_q),
    .found_o(found),
    .id_o   (win_id)
  );

  assign valid = (state_q == StFull);
  assign cap   = (!valid || fu_ready_i) && found && !flush_i;
  assign hs    = valid && fu_ready_i && !flush_i;

  // Winner mux and clear pulse; the clear is gated by reset so no entry is
  // freed while the block is being reset.
  always_comb begin
    sel_op     = '0;
    sel_a      = '0;
    sel_b      = '0;
    sel_tag    = '0;
    rs_clear_o = '0;
    for (int i = 0; i < int'(NUM_RS); i++) begin
      if (win_id == ID_W'(i)) begin
        sel_op        = rs_op_i[i];
        sel_a         = rs_vj_i[i];
        sel_b         = rs_vk_i[i];
        sel_tag       = rs_dest_i[i];
        rs_clear_o[i] = rst_ni && cap;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    tag_d    = tag_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      state_d  = StEmpty;
      rr_ptr_d = '0;
    end else begin
      if (hs && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (cap) begin
        state_d  = StFull;
        op_d     = sel_op;
        a_d      = sel_a;
        b_d      = sel_b;
        tag_d    = sel_tag;
        id_d     = win_id;
        rr_ptr_d = ID_W'(rs_id_wrap_inc(rs_id_t'(win_id), NUM_RS));
      end else if (hs) begin
        state_d = StEmpty;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StEmpty;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      tag_q    <= '0;
      id_q     <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      tag_q    <= tag_d;
      id_q     <= id_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign fu_valid_o     = valid;
  assign fu_op_o        = op_q;
  assign fu_a_o         = a_q;
  assign fu_b_o         = b_q;
  assign fu_tag_o       = tag_q;
  assign fu_rs_id_o     = id_q;
  assign dispatch_cnt_o = cnt_q;

  a_clear_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(rs_clear_o));

  a_id_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
    fu_valid_o |-> ({1'b0, fu_rs_id_o} < (ID_W + 1)'(NUM_RS)));

  a_payload_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (fu_valid_o && !fu_ready_i && !flush_i) |=>
      $stable({fu_valid_o, fu_op_o, fu_a_o, fu_b_o, fu_tag_o, fu_rs_id_o}));

endmodule

// File: tb/tb_rs_dispatch_arbiter.sv
// Scoreboard bench for rs_dispatch_arbiter: captures push expected payloads,
// FU handshakes pop them, and each scenario task checks its own outcomes.
module tb_rs_dispatch_arbiter;

  localparam int unsigned N = 3;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  tag;
    logic [2:0]  id;
  } pl_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        fu_ready;
  logic [2:0]  rs_ready;
  logic [3:0]  rs_op   [N];
  logic [15:0] rs_vj   [N];
  logic [15:0] rs_vk   [N];
  logic [2:0]  rs_dest [N];
  logic [2:0]  rs_clear;
  logic        fu_valid;
  logic [3:0]  fu_op;
  logic [15:0] fu_a, fu_b;
  logic [2:0]  fu_tag, fu_rs_id;
  logic [15:0] dispatch_cnt;

  int errors = 0;
  int checks = 0;

  pl_t         sb[$];
  logic        m_valid;
  int          m_ptr;
  logic [15:0] m_cnt;
  logic        e_cap;
  logic [2:0]  e_clear;
  int          e_win;

  rs_dispatch_arbiter dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .flush_i       (flush),
    .rs_ready_i    (rs_ready),
    .rs_op_i       (rs_op),
    .rs_vj_i       (rs_vj),
    .rs_vk_i       (rs_vk),
    .rs_dest_i     (rs_dest),
    .rs_clear_o    (rs_clear),
    .fu_valid_o    (fu_valid),
    .fu_ready_i    (fu_ready),
    .fu_op_o       (fu_op),
    .fu_a_o        (fu_a),
    .fu_b_o        (fu_b),
    .fu_tag_o      (fu_tag),
    .fu_rs_id_o    (fu_rs_id),
    .dispatch_cnt_o(dispatch_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout want finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  function automatic int m_pick(logic [2:0] rdy, int ptr);
    for (int k = 0; k < 3; k++) begin
      int j;
      j = (ptr + k) % 3;
      if (rdy[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_ptr   = 0;
    m_cnt   = 16'h0;
    sb.delete();
  endtask

  task automatic rand_payload();
    for (int i = 0; i < 3; i++) begin
      rs_op[i]   = 4'($urandom_range(0, 6));
      rs_vj[i]   = 16'($urandom);
      rs_vk[i]   = 16'($urandom);
      rs_dest[i] = 3'($urandom_range(0, 7));
    end
  endtask

  // Moves to the falling edge and derives this cycle's expected capture.
  task automatic settle();
    @(negedge clk);
    e_win   = m_pick(rs_ready, m_ptr);
    e_cap   = (!m_valid || fu_ready) && (e_win >= 0) && !flush;
    e_clear = e_cap ? (3'b001 << e_win) : 3'b000;
  endtask

  // Advances the model across the rising edge, then waits 1 unit past it.
  task automatic tick();
    logic hs;
    pl_t  p;
    hs = m_valid && fu_ready && !flush;
    @(posedge clk);
    if (flush) begin
      m_valid = 1'b0;
      m_ptr   = 0;
      sb.delete();
    end else begin
      if (hs) begin
        if (sb.size() > 0) void'(sb.pop_front());
        if (m_cnt != 16'hFFFF) m_cnt++;
      end
      if (e_cap) begin
        p.op  = rs_op[e_win];
        p.a   = rs_vj[e_win];
        p.b   = rs_vk[e_win];
        p.tag = rs_dest[e_win];
        p.id  = 3'(e_win);
        sb.push_back(p);
        m_valid = 1'b1;
        m_ptr   = (e_win + 1) % 3;
      end else if (hs) begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    flush    = 1'b0;
    fu_ready = 1'b1;
    rs_ready = 3'b111;
    rand_payload();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (fu_valid !== 1'b0 || fu_rs_id !== 3'd0 || fu_a !== 16'h0 || fu_b !== 16'h0 ||
        fu_op !== 4'h0 || fu_tag !== 3'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b id=%0d a=%h b=%h op=%h tag=%0d want all zero",
               fu_valid, fu_rs_id, fu_a, fu_b, fu_op, fu_tag);
    end
    checks++;
    if (rs_clear !== 3'b000 || dispatch_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_clear_cnt: got clear=%b cnt=%h want 000/0000", rs_clear, dispatch_cnt);
    end
    rst_n    = 1'b1;
    rs_ready = 3'b000;
  endtask

  task automatic test_single();
    rs_ready = 3'b010;
    fu_ready = 1'b1;
    settle();
    checks++;
    if (rs_clear !== 3'b010) begin
      errors++;
      $display("FAIL single_clear: got %b want 010", rs_clear);
    end
    tick();
    checks++;
    if (fu_valid !== 1'b1 || fu_rs_id !== 3'd1 || sb.size() == 0 || fu_a !== sb[0].a ||
        fu_b !== sb[0].b || fu_op !== sb[0].op || fu_tag !== sb[0].tag) begin
      errors++;
      $display("FAIL single_payload: got v=%b id=%0d a=%h want v=1 id=1 a=%h",
               fu_valid, fu_rs_id, fu_a, (sb.size() > 0) ? sb[0].a : 16'hx);
    end
    // Pointer now at 2: a fully ready vector must pick entry 2.
    rs_ready = 3'b111;
    rand_payload();
    settle();
    checks++;
    if (rs_clear !== 3'b100) begin
      errors++;
      $display("FAIL single_ptr: got clear=%b want 100", rs_clear);
    end
    tick();
    rs_ready = 3'b000;
    settle();
    tick();
    checks++;
    if (fu_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: got fu_valid=%b want 0", fu_valid);
    end
  endtask

  task automatic test_back_to_back();
    int          exp_ids[6] = '{0, 1, 2, 0, 1, 2};
    logic [15:0] base;
    base     = m_cnt;
    rs_ready = 3'b111;
    fu_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      rand_payload();
      settle();
      checks++;
      if (rs_clear !== e_clear) begin
        errors++;
        $display("FAIL b2b_clear[%0d]: got %b want %b", c, rs_clear, e_clear);
      end
      tick();
      checks++;
      if (fu_valid !== 1'b1 || fu_rs_id !== 3'(exp_ids[c]) || sb.size() == 0 ||
          fu_a !== sb[0].a || fu_b !== sb[0].b || fu_tag !== sb[0].tag) begin
        errors++;
        $display("FAIL b2b_id[%0d]: got v=%b id=%0d a=%h want v=1 id=%0d a=%h", c, fu_valid,
                 fu_rs_id, fu_a, exp_ids[c], (sb.size() > 0) ? sb[0].a : 16'hx);
      end
    end
    checks++;
    if (dispatch_cnt !== base + 16'd5) begin
      errors++;
      $display("FAIL b2b_count: got %0d want %0d", dispatch_cnt, base + 16'd5);
    end
    rs_ready = 3'b000;
    settle();
    tick();
  endtask

  task automatic test_stall();
    rs_ready = 3'b100;
    fu_ready = 1'b1;
    rand_payload();
    rs_vj[2] = 16'h1234;
    settle();
    tick();
    checks++;
    if (fu_valid !== 1'b1 || fu_rs_id !== 3'd2 || fu_a !== 16'h1234) begin
      errors++;
      $display("FAIL stall_capture: got v=%b id=%0d a=%h want 1/2/1234", fu_valid, fu_rs_id, fu_a);
    end
    fu_ready = 1'b0;
    rs_ready = 3'b001;
    for (int c = 0; c < 4; c++) begin
      rand_payload();
      settle();
      checks++;
      if (rs_clear !== 3'b000) begin
        errors++;
        $display("FAIL stall_clear[%0d]: got %b want 000", c, rs_clear);
      end
      tick();
      checks++;
      if (fu_valid !== 1'b1 || fu_rs_id !== 3'd2 || fu_a !== 16'h1234) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v=%b id=%0d a=%h want 1/2/1234", c, fu_valid,
                 fu_rs_id, fu_a);
      end
    end
    fu_ready = 1'b1;
    settle();
    checks++;
    if (rs_clear !== 3'b001) begin
      errors++;
      $display("FAIL stall_release_clear: got %b want 001", rs_clear);
    end
    tick();
    checks++;
    if (fu_valid !== 1'b1 || fu_rs_id !== 3'd0 || sb.size() == 0 || fu_a !== sb[0].a) begin
      errors++;
      $display("FAIL stall_release: got v=%b id=%0d a=%h want v=1 id=0 a=%h", fu_valid,
               fu_rs_id, fu_a, (sb.size() > 0) ? sb[0].a : 16'hx);
    end
    rs_ready = 3'b000;
    settle();
    tick();
  endtask

  task automatic test_flush();
    logic [15:0] base;
    rs_ready = 3'b010;
    fu_ready = 1'b1;
    rand_payload();
    settle();
    tick();
    base     = m_cnt;
    flush    = 1'b1;
    rs_ready = 3'b111;
    settle();
    checks++;
    if (rs_clear !== 3'b000) begin
      errors++;
      $display("FAIL flush_clear: got %b want 000", rs_clear);
    end
    tick();
    checks++;
    if (fu_valid !== 1'b0 || dispatch_cnt !== base) begin
      errors++;
      $display("FAIL flush_state: got v=%b cnt=%0d want v=0 cnt=%0d", fu_valid, dispatch_cnt, base);
    end
    flush    = 1'b0;
    rs_ready = 3'b101;
    settle();
    checks++;
    if (rs_clear !== 3'b001) begin
      errors++;
      $display("FAIL flush_ptr: got clear=%b want 001", rs_clear);
    end
    tick();
    checks++;
    if (fu_valid !== 1'b1 || fu_rs_id !== 3'd0) begin
      errors++;
      $display("FAIL flush_resume: got v=%b id=%0d want 1/0", fu_valid, fu_rs_id);
    end
    rs_ready = 3'b000;
    settle();
    tick();
  endtask

  task automatic test_saturation();
    int guard = 0;
    rs_ready = 3'b111;
    fu_ready = 1'b1;
    while (m_cnt != 16'hFFFE && guard < 70000) begin
      settle();
      tick();
      guard++;
    end
    checks++;
    if (dispatch_cnt !== 16'hFFFE) begin
      errors++;
      $display("FAIL sat_preload: got %h want FFFE", dispatch_cnt);
    end
    repeat (3) begin
      settle();
      tick();
    end
    checks++;
    if (dispatch_cnt !== 16'hFFFF || fu_valid !== 1'b1) begin
      errors++;
      $display("FAIL sat_reach: got cnt=%h v=%b want FFFF/1", dispatch_cnt, fu_valid);
    end
    repeat (2) begin
      settle();
      tick();
    end
    checks++;
    if (dispatch_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hold: got %h want FFFF", dispatch_cnt);
    end
    rs_ready = 3'b000;
    settle();
    tick();
  endtask

  task automatic test_reset_mid();
    rs_ready = 3'b111;
    fu_ready = 1'b1;
    rand_payload();
    settle();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (fu_valid !== 1'b0 || rs_clear !== 3'b000 || fu_a !== 16'h0 || fu_rs_id !== 3'd0 ||
        dispatch_cnt !== 16'h0) begin
      errors++;
      $display("FAIL midreset: got v=%b clear=%b a=%h id=%0d cnt=%h want 0/000/0000/0/0000",
               fu_valid, rs_clear, fu_a, fu_rs_id, dispatch_cnt);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    rs_ready = 3'b001;
    rand_payload();
    settle();
    checks++;
    if (rs_clear !== 3'b001) begin
      errors++;
      $display("FAIL midreset_resume_clear: got %b want 001", rs_clear);
    end
    tick();
    checks++;
    if (fu_valid !== 1'b1 || fu_rs_id !== 3'd0 || sb.size() == 0 || fu_a !== sb[0].a ||
        fu_op !== sb[0].op) begin
      errors++;
      $display("FAIL midreset_resume: got v=%b id=%0d a=%h want v=1 id=0 a=%h", fu_valid,
               fu_rs_id, fu_a, (sb.size() > 0) ? sb[0].a : 16'hx);
    end
    rs_ready = 3'b000;
    settle();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_flush();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
